// File: rtl/mem_read_ctrl_pkg.sv
// Shared definitions for the memory read controller and the memory models that talk to it.
package mem_read_ctrl_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 9;
  localparam int unsigned CntW         = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StWait  = 2'b10,
    StDone  = 2'b11
  } rd_state_e;

  // Saturating increment so a long stall can never wrap the wait counter.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_read_ctrl_reg32.sv
// Data register with load enable and asynchronous active-high clear.
module mem_read_ctrl_reg32 #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_q <= '0;
    end else if (en) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/mem_read_ctrl.sv
// Single-word read controller: issues one memory read per request, with ack timeout.
module mem_read_ctrl
  import mem_read_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W  = DefaultDataW,
  parameter int unsigned ADDR_W  = DefaultAddrW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data
);

  localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

  rd_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  logic              mem_rd_q, mem_rd_d;
  logic              data_en;
  logic              timeout_hit;

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    mem_addr_d  = mem_addr_q;
    rd_valid_d  = 1'b0;
    rd_err_d    = rd_err_q;
    mem_rd_d    = 1'b0;
    data_en     = 1'b0;
    cnt_inc     = sat_inc(cnt_q);
    timeout_hit = (cnt_inc == TimeoutCnt);

    unique case (state_q)
      StIdle: begin
        if (rd_req) begin
          state_d    = StIssue;
          mem_addr_d = rd_addr;
          rd_err_d   = 1'b0;
          mem_rd_d   = 1'b1;
        end
      end
      StIssue: begin
        state_d  = StWait;
        mem_rd_d = 1'b1;
      end
      StWait: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack) begin
          data_en    = 1'b1;
          state_d    = StDone;
          rd_valid_d = 1'b1;
        end else if (timeout_hit) begin
          state_d  = StIdle;
          rd_err_d = 1'b1;
        end else begin
          cnt_d    = cnt_inc;
          mem_rd_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      mem_rd_q   <= mem_rd_d;
    end
  end

  mem_read_ctrl_reg32 #(
    .Width (DATA_W)
  ) u_data_reg (
    .clk (clk),
    .clr (clr),
    .en  (data_en),
    .d   (mem_data),
    .q   (rd_data)
  );

  assign rd_busy  = (state_q != StIdle);
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;

endmodule

// File: tb/tb_mem_read_ctrl.sv
// Directed bench for mem_read_ctrl: reset, read, timeout, edge ack, back-to-back, spurious ack.
module tb_mem_read_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;

  logic          clk;
  logic          clr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_busy;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_err;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_ack;
  logic [DW-1:0] mem_data;

  int total = 0;
  int bad   = 0;

  mem_read_ctrl #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_err   (rd_err),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_ack  (mem_ack),
    .mem_data (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, ".busy"},  rd_busy,  1'b0);
    chk1({tag, ".valid"}, rd_valid, 1'b0);
    chk1({tag, ".err"},   rd_err,   1'b0);
    chk1({tag, ".mem_rd"}, mem_rd,  1'b0);
    chka({tag, ".mem_addr"}, mem_addr, 9'h000);
    chkd({tag, ".data"},  rd_data,  32'h0);
  endtask

  initial begin
    clr      = 1'b1;
    rd_req   = 1'b0;
    rd_addr  = '0;
    mem_ack  = 1'b0;
    mem_data = '0;

    // Asynchronous clear, checked before the first clock edge
    #3;
    chk_zero("reset");
    step();
    clr = 1'b0;
    step();
    chk_zero("post_reset_idle");

    // Basic read, ack two cycles after mem_rd rises
    rd_req  = 1'b1;
    rd_addr = 9'h0A0;
    step();                                   // ISSUE
    chk1("basic.issue_busy", rd_busy, 1'b1);
    chk1("basic.issue_mem_rd", mem_rd, 1'b1);
    chka("basic.issue_addr", mem_addr, 9'h0A0);
    rd_req  = 1'b0;
    rd_addr = 9'h1FF;
    step();                                   // WAIT cnt0
    chk1("basic.wait_mem_rd", mem_rd, 1'b1);
    chk1("basic.wait_valid", rd_valid, 1'b0);
    step();                                   // WAIT cnt1
    mem_ack  = 1'b1;
    mem_data = 32'hDEADBEEF;
    step();                                   // DONE
    mem_ack  = 1'b0;
    chk1("basic.done_valid", rd_valid, 1'b1);
    chkd("basic.done_data", rd_data, 32'hDEADBEEF);
    chk1("basic.done_mem_rd", mem_rd, 1'b0);
    chka("basic.done_addr", mem_addr, 9'h0A0);
    step();                                   // IDLE
    chk1("basic.idle_valid", rd_valid, 1'b0);
    chk1("basic.idle_busy", rd_busy, 1'b0);

    // Timeout: four WAIT cycles without ack
    rd_req  = 1'b1;
    rd_addr = 9'h033;
    step();                                   // ISSUE
    rd_req = 1'b0;
    step();                                   // WAIT cnt0
    step();                                   // WAIT cnt1
    step();                                   // WAIT cnt2
    step();                                   // WAIT cnt3
    chk1("tmo.last_wait_busy", rd_busy, 1'b1);
    chk1("tmo.last_wait_err", rd_err, 1'b0);
    step();                                   // IDLE
    chk1("tmo.err", rd_err, 1'b1);
    chk1("tmo.busy", rd_busy, 1'b0);
    chk1("tmo.valid", rd_valid, 1'b0);
    chk1("tmo.mem_rd", mem_rd, 1'b0);
    chkd("tmo.data_kept", rd_data, 32'hDEADBEEF);
    step();
    chk1("tmo.err_sticky", rd_err, 1'b1);

    // Ack on the same cycle the counter reaches TIMEOUT
    rd_req  = 1'b1;
    rd_addr = 9'h044;
    step();                                   // ISSUE
    chk1("edge.err_cleared", rd_err, 1'b0);
    rd_req = 1'b0;
    step();                                   // WAIT cnt0
    step();                                   // WAIT cnt1
    step();                                   // WAIT cnt2
    step();                                   // WAIT cnt3
    mem_ack  = 1'b1;
    mem_data = 32'h12345678;
    step();                                   // DONE
    mem_ack = 1'b0;
    chk1("edge.valid", rd_valid, 1'b1);
    chk1("edge.err", rd_err, 1'b0);
    chkd("edge.data", rd_data, 32'h12345678);
    step();
    chk1("edge.idle_valid", rd_valid, 1'b0);

    // Spurious ack while idle
    mem_ack  = 1'b1;
    mem_data = 32'hFFFFFFFF;
    step();
    step();
    chkd("spur.data", rd_data, 32'h12345678);
    chk1("spur.valid", rd_valid, 1'b0);
    chk1("spur.busy", rd_busy, 1'b0);
    mem_ack = 1'b0;

    // Back-to-back with rd_req held; also minimum latency
    rd_req  = 1'b1;
    rd_addr = 9'h001;
    step();                                   // ISSUE #1
    chka("b2b.addr1", mem_addr, 9'h001);
    rd_addr = 9'h002;
    step();                                   // WAIT #1
    chka("b2b.addr1_held", mem_addr, 9'h001);
    mem_ack  = 1'b1;
    mem_data = 32'h11;
    step();                                   // DONE #1
    mem_ack = 1'b0;
    chk1("b2b.valid1", rd_valid, 1'b1);
    chkd("b2b.data1", rd_data, 32'h11);
    step();                                   // IDLE gap
    chk1("b2b.gap_valid", rd_valid, 1'b0);
    chk1("b2b.gap_busy", rd_busy, 1'b0);
    step();                                   // ISSUE #2
    chka("b2b.addr2", mem_addr, 9'h002);
    rd_addr = 9'h1AA;
    step();                                   // WAIT #2
    mem_ack  = 1'b1;
    mem_data = 32'h22;
    step();                                   // DONE #2
    mem_ack = 1'b0;
    rd_req  = 1'b0;
    chk1("b2b.valid2", rd_valid, 1'b1);
    chkd("b2b.data2", rd_data, 32'h22);
    chka("b2b.addr2_held", mem_addr, 9'h002);
    step();

    // Clear mid-WAIT aborts silently
    rd_req  = 1'b1;
    rd_addr = 9'h005;
    step();                                   // ISSUE
    rd_req = 1'b0;
    step();                                   // WAIT cnt0
    step();                                   // WAIT cnt1
    clr = 1'b1;
    #2;
    chk_zero("midclr");
    step();
    chk1("midclr.valid_hold", rd_valid, 1'b0);
    chk1("midclr.err_hold", rd_err, 1'b0);

    // First request after clr release is taken on the first edge
    clr     = 1'b0;
    rd_req  = 1'b1;
    rd_addr = 9'h0A5;
    step();                                   // ISSUE
    chk1("post_clr.busy", rd_busy, 1'b1);
    chka("post_clr.addr", mem_addr, 9'h0A5);
    rd_req = 1'b0;
    step();                                   // WAIT
    mem_ack  = 1'b1;
    mem_data = 32'h55;
    step();                                   // DONE
    mem_ack = 1'b0;
    chk1("post_clr.valid", rd_valid, 1'b1);
    chkd("post_clr.data", rd_data, 32'h55);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_read_ctrl.md
MEM_READ_CTRL -- requirements
Module: mem_read_ctrl

Interface
REQ-001 Parameter DATA_W, 32, width of read data word.
REQ-002 Parameter ADDR_W, 9, width of word address (512-word memory).
REQ-003 Parameter TIMEOUT, 15, maximum cycles spent in WAIT before abort; legal range 1..255.
REQ-004 clk  in  1  clock; all state changes on rising edge.
REQ-005 clr  in  1  reset, asynchronous, active-high.
REQ-006 rd_req  in  1  read request from datapath; sampled only in IDLE.
REQ-007 rd_addr  in  ADDR_W  word address; captured with accepted rd_req.
REQ-008 rd_busy  out  1  high in every state except IDLE.
REQ-009 rd_valid  out  1  one-cycle pulse: rd_data holds a new word.
REQ-010 rd_data  out  DATA_W  last successfully read word; holds until next success.
REQ-011 rd_err  out  1  sticky timeout flag; cleared on next accepted rd_req.
REQ-012 mem_addr  out  ADDR_W  address to memory; registered copy of rd_addr.
REQ-013 mem_rd  out  1  memory read strobe; high in ISSUE and WAIT only.
REQ-014 mem_ack  in  1  memory acknowledge; mem_data valid in same cycle.
REQ-015 mem_data  in  DATA_W  memory read data.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, DONE, encoded in 2 bits.
REQ-017 IDLE: rd_req=1 -> capture rd_addr into mem_addr, clear rd_err, go ISSUE; else stay.
REQ-018 ISSUE: lasts exactly one cycle; mem_rd=1; unconditionally go WAIT; mem_ack ignored in ISSUE.
REQ-019 WAIT: mem_ack=1 -> latch mem_data into rd_data, go DONE.
REQ-020 WAIT: timeout counter starts at 0 on entry, increments each WAIT cycle without mem_ack; counter reaching TIMEOUT without ack -> set rd_err, go IDLE, rd_data unchanged.
REQ-021 mem_ack in the same cycle the counter reaches TIMEOUT SHALL count as success (ack wins).
REQ-022 DONE: rd_valid=1 for exactly this cycle; go IDLE next cycle.
REQ-023 Minimum latency: rd_req accepted in cycle N, mem_ack in N+2 -> rd_valid in N+3.
REQ-024 Back-to-back: rd_req held high SHALL start a new read in the cycle following DONE (one IDLE cycle between reads).
REQ-025 rd_req and rd_addr changes while rd_busy=1 SHALL be ignored; mem_addr stable for whole transaction.
REQ-026 mem_ack outside WAIT SHALL be ignored and SHALL NOT change rd_data.
REQ-027 Counter width 8 bits; SHALL saturate, never wrap.

Reset
REQ-028 clr=1 SHALL force, without clock: state IDLE, counter 0, rd_valid 0, rd_err 0, rd_busy 0, mem_rd 0, mem_addr 0, rd_data 0.
REQ-029 clr asserted mid-transaction SHALL abort it silently: no rd_valid, no rd_err, rd_data cleared to 0.
REQ-030 First rd_req after clr deassertion SHALL be accepted on the first rising edge with clr=0.

Structure
REQ-031 State encoding constants and default DATA_W/ADDR_W SHALL live in the shared CPU package, also used by the memory model.
REQ-032 rd_data SHALL be built from the existing 32-bit register block (enable = WAIT and mem_ack, async clr); no other sub-module.
REQ-033 All outputs except rd_busy SHALL be registered; rd_busy decoded from state.

Verification
REQ-034 Reset: clr pulsed mid-WAIT with addr 0x05 -> all outputs 0 next sample, no rd_valid ever.
REQ-035 Basic read: rd_req, rd_addr=0x0A0, memory acks 2 cycles after mem_rd with 0xDEADBEEF -> rd_valid one cycle, rd_data=0xDEADBEEF, mem_addr=0x0A0 throughout.
REQ-036 Timeout: TIMEOUT=4, no ack -> rd_err=1 after 4 WAIT cycles, return IDLE, rd_data keeps prior 0xDEADBEEF, no rd_valid.
REQ-037 Edge ack: ack arrives on the cycle counter hits TIMEOUT with 0x12345678 -> success, rd_err=0, rd_data=0x12345678.
REQ-038 Back-to-back: rd_req held, addrs 0x001 then 0x002, ack 0x11/0x22 -> two rd_valid pulses 1 IDLE cycle apart, correct data order; rd_addr toggled while busy has no effect.
REQ-039 Spurious ack: mem_ack=1 with 0xFFFFFFFF while IDLE -> rd_data, rd_valid unchanged.
